// File: rtl/ysyx_store_buffer.sv
// Committed-store FIFO feeding the single-outstanding bus store port.
// Drains in program order and flags word-address conflicts for younger loads.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_store_buffer_match #(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic [XLEN-1:0] entry_addr,
    input  logic [XLEN-1:0] ld_addr,
    output logic            hit
);
    // Word granularity: the byte offset bits are shifted out of the compare.
    assign hit = valid && (((entry_addr ^ ld_addr) >> 2) == '0);
endmodule

module ysyx_store_buffer #(
    parameter int XLEN  = `YSYX_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_addr,
    input  logic [XLEN-1:0]          in_data,
    input  logic [7:0]               in_wstrb,
    output logic                     out_ready,
    output logic [XLEN-1:0]          out_awaddr,
    output logic                     out_awvalid,
    output logic [XLEN-1:0]          out_wdata,
    output logic [7:0]               out_wstrb,
    output logic                     out_wvalid,
    input  logic                     bus_wready,
    input  logic                     ld_valid,
    input  logic [XLEN-1:0]          ld_addr,
    output logic                     out_ld_hit,
    output logic                     out_empty,
    output logic [$clog2(DEPTH):0]   out_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [7:0]      wstrb;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] hit_vec;

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    // Fullness is judged on the registered pointers only; a same-cycle pop does not free a slot.
    assign push  = in_valid && !full;
    assign pop   = bus_wready && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= '{addr: in_addr, data: in_data, wstrb: in_wstrb};
    end

    assign head        = mem[rptr[AW-1:0]];
    assign out_awaddr  = head.addr;
    assign out_wdata   = head.data;
    assign out_wstrb   = head.wstrb;
    assign out_awvalid = !empty;
    assign out_wvalid  = !empty;
    assign out_ready   = !full;
    assign out_empty   = empty;
    assign out_count   = count;

    // Entry i is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] offs;
        logic          live;
        assign offs = AW'(i) - rptr[AW-1:0];
        assign live = ({1'b0, offs} < count);
        ysyx_store_buffer_match #(.XLEN(XLEN)) u_match (
            .valid      (live),
            .entry_addr (mem[i].addr),
            .ld_addr    (ld_addr),
            .hit        (hit_vec[i])
        );
    end

    assign out_ld_hit = ld_valid && (|hit_vec);
endmodule

// File: tb/tb_ysyx_store_buffer.sv
// Self-checking bench: a table of directed cycles plus scoreboarded sequences
// for ordering/wrap and mid-operation reset.
module tb_ysyx_store_buffer;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  in_wstrb;
    logic        out_ready;
    logic [31:0] out_awaddr;
    logic        out_awvalid;
    logic [31:0] out_wdata;
    logic [7:0]  out_wstrb;
    logic        out_wvalid;
    logic        bus_wready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        out_ld_hit;
    logic        out_empty;
    logic [2:0]  out_count;

    ysyx_store_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_wstrb    (in_wstrb),
        .out_ready   (out_ready),
        .out_awaddr  (out_awaddr),
        .out_awvalid (out_awvalid),
        .out_wdata   (out_wdata),
        .out_wstrb   (out_wstrb),
        .out_wvalid  (out_wvalid),
        .bus_wready  (bus_wready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .out_ld_hit  (out_ld_hit),
        .out_empty   (out_empty),
        .out_count   (out_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  wstrb;
    } st_t;

    typedef struct {
        logic        iv;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        logic        bw;
        logic        lv;
        logic [31:0] la;
        int          exp_count;
        logic        exp_awv;
        logic        exp_hit;
    } vec_t;

    st_t  q[$];
    vec_t vt[$];
    int   nchk = 0;
    int   nerr = 0;
    int   npop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hit(input logic lv, input logic [31:0] la);
        logic h = 1'b0;
        foreach (q[k]) if (q[k].addr[31:2] == la[31:2]) h = 1'b1;
        return lv && h;
    endfunction

    // One cycle: drive after negedge, check settled outputs against the model, advance at posedge.
    task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] id,
                         input logic [7:0] is, input logic bw, input logic lv,
                         input logic [31:0] la, output logic acc);
        int  sz;
        st_t e;
        in_valid = iv; in_addr = ia; in_data = id; in_wstrb = is;
        bus_wready = bw; ld_valid = lv; ld_addr = la;
        #1;
        sz = q.size();
        chk("count", 32'(out_count), 32'(sz));
        chk("ready", 32'(out_ready), 32'(sz < DEPTH));
        chk("empty", 32'(out_empty), 32'(sz == 0));
        chk("awvalid", 32'(out_awvalid), 32'(sz != 0));
        chk("wvalid", 32'(out_wvalid), 32'(sz != 0));
        if (sz != 0) begin
            chk("awaddr", out_awaddr, q[0].addr);
            chk("wdata", out_wdata, q[0].data);
            chk("wstrb", 32'(out_wstrb), 32'(q[0].wstrb));
        end
        chk("ld_hit", 32'(out_ld_hit), 32'(model_hit(lv, la)));
        acc = iv && (sz < DEPTH);
        @(posedge clock);
        if (bw && sz != 0) begin
            e = q.pop_front();
            npop++;
        end
        if (acc) q.push_back('{addr: ia, data: id, wstrb: is});
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; bus_wready = 1'b0; ld_valid = 1'b0;
        in_addr = '0; in_data = '0; in_wstrb = '0; ld_addr = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
    endtask

    function automatic vec_t v(input logic iv, input logic [31:0] a, input logic [31:0] d,
                               input logic [7:0] s, input logic bw, input logic lv,
                               input logic [31:0] la, input int c, input logic awv, input logic h);
        vec_t r;
        r.iv = iv; r.addr = a; r.data = d; r.strb = s; r.bw = bw; r.lv = lv; r.la = la;
        r.exp_count = c; r.exp_awv = awv; r.exp_hit = h;
        return r;
    endfunction

    initial begin
        logic acc;
        int   pushed;
        int   cyc;

        // Single store, fill/back-pressure, load hit, push+pop at count 2.
        vt.push_back(v(1, 32'h8000_0010, 32'hDEAD_BEEF, 8'hf, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h200, 32'h0, 8'h1, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h204, 32'h1, 8'h3, 0, 0, 0, 1, 1, 0));
        vt.push_back(v(1, 32'h208, 32'h2, 8'hf, 0, 0, 0, 2, 1, 0));
        vt.push_back(v(1, 32'h20c, 32'h3, 8'hf, 0, 0, 0, 3, 1, 0));
        vt.push_back(v(1, 32'h210, 32'h4, 8'hf, 1, 0, 0, 4, 1, 0));
        vt.push_back(v(1, 32'h210, 32'h4, 8'hf, 0, 0, 0, 3, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 4, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 4, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 3, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 2, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h8000_0022, 32'h5a, 8'h1, 0, 1, 32'h8000_0020, 0, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 32'h8000_0020, 1, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 32'h8000_0024, 1, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 32'h8000_0023, 1, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 32'h8000_0020, 0, 0, 0));
        vt.push_back(v(1, 32'h300, 32'h11, 8'hf, 0, 0, 0, 0, 0, 0));
        vt.push_back(v(1, 32'h304, 32'h22, 8'hf, 0, 0, 0, 1, 1, 0));
        vt.push_back(v(1, 32'h308, 32'h33, 8'hf, 1, 0, 0, 2, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 2, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        @(negedge clock);
        do_reset();
        do_reset();

        for (int i = 0; i < vt.size(); i++) begin
            in_valid = vt[i].iv; in_addr = vt[i].addr; in_data = vt[i].data;
            in_wstrb = vt[i].strb; bus_wready = vt[i].bw;
            ld_valid = vt[i].lv; ld_addr = vt[i].la;
            #1;
            chk($sformatf("vec%0d_count", i), 32'(out_count), 32'(vt[i].exp_count));
            chk($sformatf("vec%0d_awvalid", i), 32'(out_awvalid), 32'(vt[i].exp_awv));
            chk($sformatf("vec%0d_hit", i), 32'(out_ld_hit), 32'(vt[i].exp_hit));
            cycle(vt[i].iv, vt[i].addr, vt[i].data, vt[i].strb, vt[i].bw,
                  vt[i].lv, vt[i].la, acc);
        end

        // Ten ordered stores with random drain pulses; exercises pointer wrap.
        npop = 0;
        pushed = 0;
        cyc = 0;
        while ((pushed < 10 || q.size() != 0) && cyc < 300) begin
            cycle(pushed < 10, 32'h100 + 32'(4 * pushed), 32'(pushed), 8'hf,
                  1'($urandom_range(0, 1)), 1'b1, 32'h100 + 32'(4 * $urandom_range(0, 11)), acc);
            if (acc) pushed++;
            cyc++;
        end
        chk("order_pops", 32'(npop), 32'd10);
        chk("order_timeout", 32'(cyc < 300), 32'd1);

        // Reset with three entries buffered, then a stray bus_wready.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 8'hf, 1'b0, 1'b0, 0, acc);
        chk("pre_reset_count", 32'(out_count), 32'd3);
        do_reset();
        #1;
        chk("rst_empty", 32'(out_empty), 32'd1);
        chk("rst_awvalid", 32'(out_awvalid), 32'd0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1, 32'h400, acc);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, acc);
        chk("stray_count", 32'(out_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/ysyx_store_buffer.md
# ysyx_store_buffer

Committed-store FIFO between the LSU store path and the bus store port (`lsu_aw*`/`lsu_w*`/`out_lsu_wready`). It absorbs retired stores at one per cycle, drains them in program order through the bus's single-outstanding AW/W/B sequence, and reports word-address conflicts so younger loads stall until the matching store has drained. Only committed stores enter, so pipeline flush never touches its contents.

## Interface
- `XLEN`, default `` `YSYX_XLEN `` (32): address/data width.
- `DEPTH`, default 4: entry count; power of two, ≥2.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  committed store offered.
- `in_addr`  in  XLEN  store byte address.
- `in_data`  in  XLEN  store data, LSB-aligned (bus shifts by addr[1:0]).
- `in_wstrb`  in  8  byte mask, LSB-aligned: 8'h1, 8'h3 or 8'hf.
- `out_ready`  out  1  = !full; store accepted when `in_valid && out_ready`.
- `out_awaddr`  out  XLEN  head entry address, to bus `lsu_awaddr`.
- `out_awvalid`  out  1  head valid, to bus `lsu_awvalid`.
- `out_wdata`  out  XLEN  head data, to bus `lsu_wdata`.
- `out_wstrb`  out  8  head mask, to bus `lsu_wstrb`.
- `out_wvalid`  out  1  identical to `out_awvalid`, to bus `lsu_wvalid`.
- `bus_wready`  in  1  from bus `out_lsu_wready`; one-cycle B-response pulse.
- `ld_valid`  in  1  LSU load request active.
- `ld_addr`  in  XLEN  load byte address.
- `out_ld_hit`  out  1  load word overlaps a buffered store.
- `out_empty`  out  1  no entries; used by fence / fence.i / MMIO ordering.
- `out_count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH entries {addr, data, wstrb}; read/write pointers of $clog2(DEPTH)+1 bits with the MSB as the wrap bit. empty = pointers equal; full = index bits equal and wrap bits differ. Storage is not reset; only pointers are.
- Enqueue: on `in_valid && out_ready`, write the entry at the write pointer, then increment it. No acceptance when full, even if a pop occurs in the same cycle. Fullness is not bypassed.
- Drain: `out_awvalid = out_wvalid = !empty`. Head fields are driven combinationally from the read-pointer entry and held stable while valid. On `bus_wready && !empty`, increment the read pointer. `bus_wready` while empty is ignored.
- Bus handshake rule: the bus latches the request when idle and runs W and B. After the B pulse it spends one cycle in its B state before it samples `lsu_awvalid` again. Holding the next head valid across that cycle is legal and required.
- Simultaneous enqueue and pop (not full): both pointers advance and `out_count` is unchanged.
- Load conflict: `out_ld_hit = ld_valid` AND some valid entry has `addr[XLEN-1:2] == ld_addr[XLEN-1:2]`. The check is combinational over all valid entries, including the head being drained. The head stays a hit until the cycle after its `bus_wready`. There is no forwarding: the LSU holds the load until the hit clears.
- Valid-entry mask: entry i is valid iff it lies in [rptr, wptr) modulo DEPTH, using the wrap bits.
- Reset mid-operation: pointers clear and the buffer becomes empty. Any store the bus already latched completes on the bus side, and its later `bus_wready` is ignored because the buffer is empty.

## Timing
- Reset values: `out_ready`=1, `out_awvalid`=`out_wvalid`=0, `out_empty`=1, `out_count`=0, `out_ld_hit`=0. `out_awaddr`/`out_wdata`/`out_wstrb` are don't-care while invalid.
- Enqueue into an empty buffer at cycle N: `out_awvalid`=1 in cycle N+1 (registered, no same-cycle bypass).
- Pop at cycle M (`bus_wready`=1): in cycle M+1 the head is the next entry, or `out_awvalid`=0 if the buffer became empty.
- `out_ready` falls in the cycle after the DEPTH-th outstanding accept. It rises in the cycle after the pop.
- Throughput: enqueue 1 per cycle until full. Drain is limited by bus latency to at least 3 cycles per store.
- `out_ld_hit`, `out_empty` and `out_count` reflect the registered pointers of the current cycle. Zero-cycle combinational path from `ld_*`.

## Test plan
- Single store: enqueue addr 0x8000_0010, data 0xDEAD_BEEF, wstrb 8'hf at cycle 1. Required: awvalid=1 with those fields at cycle 2 and held until `bus_wready`; `out_empty`=1 the cycle after the pulse.
- Fill and back-pressure, DEPTH=4: four back-to-back stores. Required: `out_ready`=0 and `out_count`=4. A fifth store offered with `bus_wready` in the same cycle is not accepted; it is accepted the next cycle and `out_count` returns to 4.
- Ordering and wrap: 10 stores with addr 0x100+4i and data i, interleaved with random `bus_wready` pulses. Required: the bus sees addr/data in order 0..9 and pointer wrap is correct.
- Load hit: buffer holds a store to 0x8000_0022 with wstrb 8'h1. A load to 0x8000_0020 gives `out_ld_hit`=1; a load to 0x8000_0024 gives 0. After that store's `bus_wready`, the hit drops the next cycle.
- Simultaneous push/pop at count 2: `out_count` stays 2 and the head advances to the second entry.
- Reset with 3 entries buffered: next cycle `out_empty`=1, `out_awvalid`=0; a stray `bus_wready` keeps `out_count`=0.
